// File: rtl/encoder_pkg.sv
// Shared widths, reset value and output payload for the 8-to-3 encoder.
package encoder_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CODE_W = $clog2(DATA_W);
  localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

  localparam logic [CODE_W-1:0] CODE_RST = 3'd0;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              valid;
    logic              multi;
  } enc_out_t;

  localparam enc_out_t ENC_OUT_RST = '{code: CODE_RST, valid: 1'b0, multi: 1'b0};

endpackage : encoder_pkg

// File: rtl/encoder_8x3_if.sv
// Request vector in, combinational and registered index/flags out.
interface encoder_8x3_if;
  import encoder_pkg::*;

  logic [DATA_W-1:0] data;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              multi;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              multi_q;

  modport master (
    output data,
    input  code, valid, multi, code_q, valid_q, multi_q
  );

  modport slave (
    input  data,
    output code, valid, multi, code_q, valid_q, multi_q
  );

endinterface : encoder_8x3_if

// File: rtl/encoder_8x3_core.sv
// Purely combinational priority encoder with valid and multi-hot flags.
module encoder_8x3_core
  import encoder_pkg::*;
#(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic [DATA_W-1:0] data_i,
  output enc_out_t          out_o
);

  logic [CODE_W-1:0] code_c;
  logic [CNT_W-1:0]  cnt_c;

  // Scan order sets the winner: the last set bit visited overwrites earlier ones.
  always_comb begin
    code_c = CODE_RST;
    if (HIGH_PRIORITY) begin
      for (int i = 0; i < int'(DATA_W); i++) begin
        if (data_i[i]) code_c = CODE_W'(i);
      end
    end else begin
      for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
        if (data_i[i]) code_c = CODE_W'(i);
      end
    end
  end

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      cnt_c = cnt_c + CNT_W'(data_i[i]);
    end
  end

  always_comb begin
    out_o       = ENC_OUT_RST;
    out_o.code  = code_c;
    out_o.valid = |data_i;
    out_o.multi = (cnt_c >= CNT_W'(2));
  end

endmodule : encoder_8x3_core

// File: rtl/encoder_8x3.sv
// 8-to-3 encoder top: combinational core plus async-reset output register stage.
module encoder_8x3
  import encoder_pkg::*;
#(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  encoder_8x3_if.slave  bus
);

  enc_out_t enc_c;
  enc_out_t out_d;
  enc_out_t out_q;

  encoder_8x3_core #(
    .HIGH_PRIORITY (HIGH_PRIORITY)
  ) u_core (
    .data_i (bus.data),
    .out_o  (enc_c)
  );

  assign out_d = enc_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= ENC_OUT_RST;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.code    = enc_c.code;
  assign bus.valid   = enc_c.valid;
  assign bus.multi   = enc_c.multi;
  assign bus.code_q  = out_q.code;
  assign bus.valid_q = out_q.valid;
  assign bus.multi_q = out_q.multi;

endmodule : encoder_8x3

// File: tb/tb_encoder_8x3.sv
// Scoreboard bench for encoder_8x3 with both priority settings side by side.
module tb_encoder_8x3;
  import encoder_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [2:0] code_hi;
    logic [2:0] code_lo;
    logic       valid;
    logic       multi;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  encoder_8x3_if if_hi ();
  encoder_8x3_if if_lo ();

  encoder_8x3 #(.HIGH_PRIORITY(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(if_hi.slave));
  encoder_8x3 #(.HIGH_PRIORITY(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(if_lo.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector on the falling edge and queue what both DUTs must show.
  task automatic drive(input logic [7:0] d, input logic [2:0] hi, input logic [2:0] lo,
                       input logic v, input logic m);
    exp_t e;
    @(negedge clk);
    if_hi.data = d;
    if_lo.data = d;
    e.data = d; e.code_hi = hi; e.code_lo = lo; e.valid = v; e.multi = m;
    sb_q.push_back(e);
  endtask

  // Monitor: data is stable across the rising edge, so combinational and
  // registered outputs are compared against the same queued entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("code_hi[%h]", e.data),    8'(if_hi.code),    8'(e.code_hi));
      chk($sformatf("code_lo[%h]", e.data),    8'(if_lo.code),    8'(e.code_lo));
      chk($sformatf("valid[%h]", e.data),      8'(if_hi.valid),   8'(e.valid));
      chk($sformatf("multi[%h]", e.data),      8'(if_lo.multi),   8'(e.multi));
      chk($sformatf("code_q_hi[%h]", e.data),  8'(if_hi.code_q),  8'(e.code_hi));
      chk($sformatf("code_q_lo[%h]", e.data),  8'(if_lo.code_q),  8'(e.code_lo));
      chk($sformatf("valid_q[%h]", e.data),    8'(if_hi.valid_q), 8'(e.valid));
      chk($sformatf("multi_q[%h]", e.data),    8'(if_lo.multi_q), 8'(e.multi));
    end
  end

  initial begin
    int wait_cycles;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if_hi.data = 8'h00;
    if_lo.data = 8'h00;
    #1;
    chk("rst_code_q",  8'(if_hi.code_q),  8'h00);
    chk("rst_valid_q", 8'(if_hi.valid_q), 8'h00);
    chk("rst_multi_q", 8'(if_lo.multi_q), 8'h00);
    @(negedge clk);
    if_hi.data = 8'h01;
    if_lo.data = 8'h01;
    #1;
    chk("comb_in_reset_valid", 8'(if_hi.valid),  8'h01);
    chk("reg_in_reset_valid",  8'(if_hi.valid_q), 8'h00);
    rst = 1'b0;

    // One-hot walk
    drive(8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
    drive(8'h02, 3'd1, 3'd1, 1'b1, 1'b0);
    drive(8'h04, 3'd2, 3'd2, 1'b1, 1'b0);
    drive(8'h08, 3'd3, 3'd3, 1'b1, 1'b0);
    drive(8'h10, 3'd4, 3'd4, 1'b1, 1'b0);
    drive(8'h20, 3'd5, 3'd5, 1'b1, 1'b0);
    drive(8'h40, 3'd6, 3'd6, 1'b1, 1'b0);
    drive(8'h80, 3'd7, 3'd7, 1'b1, 1'b0);
    // Zero and multi-hot cases
    drive(8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
    drive(8'h94, 3'd7, 3'd2, 1'b1, 1'b1);
    drive(8'hFF, 3'd7, 3'd0, 1'b1, 1'b1);
    drive(8'h18, 3'd4, 3'd3, 1'b1, 1'b1);
    drive(8'h03, 3'd1, 3'd0, 1'b1, 1'b1);
    drive(8'h81, 3'd7, 3'd0, 1'b1, 1'b1);
    // Back-to-back changes
    drive(8'h01, 3'd0, 3'd0, 1'b1, 1'b0);
    drive(8'h02, 3'd1, 3'd1, 1'b1, 1'b0);
    drive(8'h04, 3'd2, 3'd2, 1'b1, 1'b0);

    // Async reset pulse between edges with code_q holding 6
    drive(8'h40, 3'd6, 3'd6, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("pre_rst_code_q", 8'(if_hi.code_q), 8'h06);
    rst = 1'b1;
    #1;
    chk("async_rst_code_q",  8'(if_hi.code_q),  8'h00);
    chk("async_rst_valid_q", 8'(if_hi.valid_q), 8'h00);
    chk("async_rst_multi_q", 8'(if_lo.multi_q), 8'h00);
    chk("async_rst_code",    8'(if_hi.code),    8'h06);
    chk("async_rst_valid",   8'(if_lo.valid),   8'h01);
    #1;
    rst = 1'b0;
    sb_q.push_back('{data: 8'h40, code_hi: 3'd6, code_lo: 3'd6, valid: 1'b1, multi: 1'b0});

    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_encoder_8x3
